seq_det_sched: RTL and testbench
================================

# seq_det_sched

Programmable serial sequence-detection controller that sequences a bit-serial pattern detector through configure, run and finish phases. It counts pattern matches on a valid-qualified serial stream and stops on a match target, a bit timeout or an abort. It sits between a configuration/control master and the serial input of the FSM test designs.

## Interface

- PW, 8, maximum pattern length in bits (2..16)
- CW, 8, match counter width
- TW, 16, timeout (bit) counter width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  configuration write strobe (honoured in IDLE only)
- cfg_pat  in  PW  pattern; bit [len-1] is first bit on the wire, bit 0 is last
- cfg_len  in  $clog2(PW)+1  pattern length, legal 1..PW
- cfg_ovl  in  1  1 = overlapping matches allowed
- cfg_target  in  CW  matches to collect before stop; 0 = unlimited
- cfg_timeout  in  TW  accepted-bit limit per run; 0 = none
- start  in  1  begin run (IDLE only)
- abort  in  1  terminate run
- x  in  1  serial data bit
- x_vld  in  1  x is valid this cycle
- z  out  1  one-cycle match pulse
- match_cnt  out  CW  matches in current/last run
- busy  out  1  state != IDLE
- done  out  1  one-cycle end-of-run pulse
- timeout  out  1  last run ended by timeout (sticky until next start)
- cfg_err  out  1  one-cycle pulse: illegal cfg_len rejected

## Operation

- States: IDLE, RUN, DONE.
- IDLE: cfg_we with 1 <= cfg_len <= PW loads pat/len/ovl/target/timeout registers; illegal len leaves registers unchanged, pulses cfg_err next cycle. cfg_we and start in the same cycle: cfg_we wins, start ignored.
- IDLE -> RUN on start: clears history shift register, fill counter, bit counter, match_cnt, timeout.
- RUN, per cycle with x_vld=1 (an accepted bit): hist <= {hist[PW-2:0], x}; fill <= min(fill+1, len); bitcnt++.
- Match on an accepted bit when fill+1 >= len and the low len bits of {hist, x} equal the low len bits of pat.
- On match: z=1 next cycle; match_cnt++ (saturates at all-ones when target=0); if cfg_ovl=0, fill <= 0 (no bit of this match reused).
- RUN -> DONE, evaluated on the same edge, priority order: abort (bit not consumed, no match counted); target!=0 and match_cnt+1 == target on a match; timeout!=0 and bitcnt+1 == timeout (timeout <= 1 unless this bit hit target).
- x_vld=0 in RUN: no state change except abort.
- DONE: done=1 for exactly one cycle, then IDLE. Inputs other than rst ignored.
- start in RUN/DONE ignored; cfg_we outside IDLE ignored (no cfg_err).
- Stored configuration persists across runs and is cleared only by reset.

## Timing

- Reset (rst=0, async): state=IDLE; z=0, match_cnt=0, busy=0, done=0, timeout=0, cfg_err=0; config registers: pat=0, len=1, ovl=0, target=0, timeout=0. Reset during RUN aborts immediately without a done pulse.
- All outputs registered.
- Bit sampled at edge k -> z high cycle k+1 for one cycle; match_cnt already updated in cycle k+1.
- Ending bit at edge k: busy high, done high in cycle k+1; busy low from cycle k+2; next start is accepted at edge k+2.
- Abort at edge k: done in cycle k+1, z stays 0.
- start at edge k: first bit can be accepted at edge k+1.
- Back-to-back accepted bits every cycle supported; z may be high on consecutive cycles (len=1, or overlap with a periodic pattern).

## Test plan

- len=4, pat=1010, ovl=1, target=0, timeout=0; stream 1,0,1,0,1,0,1 every cycle -> z after bits 4 and 6; match_cnt=2; no done.
- Same stream, ovl=0 -> z after bit 4 only; match_cnt=1.
- pat=1010, ovl=1, target=2; stream 1,0,1,0,1,0 -> done in cycle after bit 6, match_cnt=2, timeout=0, busy low one cycle later.
- pat=1111, len=4, timeout=5; stream 1,0,1,0,1 -> done after bit 5, timeout=1, match_cnt=0. Then target=1, timeout=4, stream 1,1,1,1 -> match on bit 4 wins, timeout=0.
- cfg_len=0 and cfg_len=PW+1 in IDLE -> cfg_err pulses, old config retained; cfg_we during RUN -> ignored, no cfg_err.
- Reset mid-RUN after 2 bits -> all outputs 0 immediately, no done; abort with matching bit same cycle -> no z, match_cnt unchanged, done next cycle.

Source files
------------

// File: rtl/seq_det_sched.sv
// Serial pattern-detection run controller with configure, run and finish phases.
// Counts matches on a valid-qualified bit stream until target, bit timeout or abort.
module seq_det_sched #(
  parameter int PW = 8,
  parameter int CW = 8,
  parameter int TW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [PW-1:0]        cfg_pat,
  input  logic [$clog2(PW):0]  cfg_len,
  input  logic                 cfg_ovl,
  input  logic [CW-1:0]        cfg_target,
  input  logic [TW-1:0]        cfg_timeout,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 x,
  input  logic                 x_vld,
  output logic                 z,
  output logic [CW-1:0]        match_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 cfg_err
);

  localparam int LW = $clog2(PW) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovl_q, ovl_d;
  logic [CW-1:0] tgt_q, tgt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-2:0] hist_q, hist_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [TW-1:0] bitcnt_q, bitcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_q, z_d;
  logic          done_q, done_d;
  logic          tflag_q, tflag_d;
  logic          err_q, err_d;

  logic [PW-1:0] mask;
  logic [PW-1:0] nxt_hist;
  logic [LW:0]   fill_inc;
  logic [CW-1:0] cnt_inc;
  logic [TW-1:0] bit_inc;
  logic          len_ok;
  logic          hit;
  logic          tgt_end;
  logic          tmo_end;

  // Only the newest len bits take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PW; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign len_ok   = (cfg_len != '0) && (cfg_len <= LW'(PW));
  assign nxt_hist = {hist_q, x};
  assign fill_inc = {1'b0, fill_q} + (LW+1)'(1);
  assign cnt_inc  = cnt_q + CW'(1);
  assign bit_inc  = bitcnt_q + TW'(1);
  assign hit      = (fill_inc >= {1'b0, len_q}) &&
                    (((nxt_hist ^ pat_q) & mask) == '0);
  assign tgt_end  = hit && (tgt_q != '0) && (cnt_inc == tgt_q);
  assign tmo_end  = (tmo_q != '0) && (bit_inc == tmo_q);

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    tgt_d    = tgt_q;
    tmo_d    = tmo_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    bitcnt_d = bitcnt_q;
    cnt_d    = cnt_q;
    tflag_d  = tflag_q;
    z_d      = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          if (len_ok) begin
            pat_d = cfg_pat;
            len_d = cfg_len;
            ovl_d = cfg_ovl;
            tgt_d = cfg_target;
            tmo_d = cfg_timeout;
          end else begin
            err_d = 1'b1;
          end
        end else if (start) begin
          state_d  = S_RUN;
          hist_d   = '0;
          fill_d   = '0;
          bitcnt_d = '0;
          cnt_d    = '0;
          tflag_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (x_vld) begin
          hist_d   = nxt_hist[PW-2:0];
          fill_d   = (fill_inc >= {1'b0, len_q}) ? len_q
                                                 : fill_inc[LW-1:0];
          bitcnt_d = bit_inc;
          if (hit) begin
            z_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_inc;
            // Non-overlapping: the next match must use fresh bits.
            if (!ovl_q) fill_d = '0;
          end
          if (tgt_end) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (tmo_end) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            tflag_d = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      len_q    <= LW'(1);
      ovl_q    <= 1'b0;
      tgt_q    <= '0;
      tmo_q    <= '0;
      hist_q   <= '0;
      fill_q   <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
      tflag_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      tgt_q    <= tgt_d;
      tmo_q    <= tmo_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      done_q   <= done_d;
      tflag_q  <= tflag_d;
      err_q    <= err_d;
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign timeout   = tflag_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: directed scenarios plus a random run
// against a queue-based reference model of the detector.
module tb_seq_det_sched;

  localparam int PW = 8;
  localparam int CW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [PW-1:0] cfg_pat;
  logic [3:0]    cfg_len;
  logic          cfg_ovl;
  logic [CW-1:0] cfg_target;
  logic [TW-1:0] cfg_timeout;
  logic          start, abort, x, x_vld;
  logic          z, busy, done, timeout, cfg_err;
  logic [CW-1:0] match_cnt;

  int errors = 0;
  int checks = 0;

  seq_det_sched #(.PW(PW), .CW(CW), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .cfg_target(cfg_target),
    .cfg_timeout(cfg_timeout),
    .start(start), .abort(abort), .x(x), .x_vld(x_vld),
    .z(z), .match_cnt(match_cnt), .busy(busy), .done(done),
    .timeout(timeout), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // reference model: 0 idle, 1 run, 2 done
  int   m_st, m_len, m_tgt, m_tmo, m_bits, m_cnt;
  logic [PW-1:0] m_pat;
  bit   m_ovl, m_z, m_done, m_tf, m_err;
  bit   win[$];

  task automatic mdl_reset();
    m_st = 0; m_pat = '0; m_len = 1; m_ovl = 0; m_tgt = 0; m_tmo = 0;
    win.delete(); m_bits = 0; m_cnt = 0;
    m_z = 0; m_done = 0; m_tf = 0; m_err = 0;
  endtask

  task automatic mdl_step();
    bit hit, tend;
    int n;
    m_z = 0; m_done = 0; m_err = 0;
    if (m_st == 0) begin
      if (cfg_we) begin
        if (cfg_len >= 1 && cfg_len <= PW) begin
          m_pat = cfg_pat; m_len = int'(cfg_len); m_ovl = cfg_ovl;
          m_tgt = int'(cfg_target); m_tmo = int'(cfg_timeout);
        end else m_err = 1;
      end else if (start) begin
        m_st = 1; win.delete(); m_bits = 0; m_cnt = 0; m_tf = 0;
      end
    end else if (m_st == 1) begin
      if (abort) begin
        m_st = 2; m_done = 1;
      end else if (x_vld) begin
        win.push_back(x);
        if (win.size() > PW) void'(win.pop_front());
        n = win.size();
        hit = (n >= m_len);
        for (int j = 0; j < m_len && hit; j++)
          if (win[n-1-j] != m_pat[j]) hit = 0;
        tend = hit && m_tgt != 0 && m_cnt + 1 == m_tgt;
        m_bits++;
        if (hit) begin
          m_z = 1;
          if (m_cnt < 255) m_cnt++;
          if (!m_ovl) win.delete();
        end
        if (tend) begin
          m_st = 2; m_done = 1;
        end else if (m_tmo != 0 && m_bits == m_tmo) begin
          m_st = 2; m_done = 1; m_tf = 1;
        end
      end
    end else begin
      m_st = 0;
    end
  endtask

  function automatic logic [12:0] mexp();
    return {m_z, 8'(m_cnt), m_st != 0, m_done, m_tf, m_err};
  endfunction

  function automatic logic [12:0] obs();
    return {z, match_cnt, busy, done, timeout, cfg_err};
  endfunction

  task automatic tick();
    mdl_step();
    @(posedge clk);
    #1;
    cfg_we = 0; start = 0; abort = 0; x_vld = 0;
  endtask

  task automatic cfg(input logic [7:0] p, input int l, input bit o,
                     input int t, input int tm);
    cfg_we = 1; cfg_pat = p; cfg_len = 4'(l); cfg_ovl = o;
    cfg_target = 8'(t); cfg_timeout = 16'(tm);
    tick();
  endtask

  task automatic go();
    start = 1;
    tick();
  endtask

  task automatic bitin(input bit b);
    x = b; x_vld = 1;
    tick();
  endtask

  task automatic test_reset();
    rst = 0; cfg_we = 0; start = 0; abort = 0; x = 0; x_vld = 0;
    cfg_pat = 0; cfg_len = 0; cfg_ovl = 0; cfg_target = 0;
    cfg_timeout = 0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", obs());
    end
    @(negedge clk) rst = 1;
    go();
    bitin(0);
    checks++;
    if (z !== 1'b1 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL reset_cfg z=%b cnt=%0d want z=1 cnt=1",
               z, match_cnt);
    end
    abort = 1; tick(); tick();
    checks++;
    if (obs() !== mexp()) begin
      errors++;
      $display("FAIL reset_end got=%h want=%h", obs(), mexp());
    end
  endtask

  task automatic test_stream(input bit ovl, input logic [6:0] want_z,
                             input int want_cnt);
    logic [6:0] s = 7'b1010101;
    logic [6:0] zs = '0;
    cfg(8'b1010, 4, ovl, 0, 0);
    go();
    for (int i = 0; i < 7; i++) begin
      bitin(s[6-i]);
      zs[i] = z;
      checks++;
      if (obs() !== mexp()) begin
        errors++;
        $display("FAIL stream_ovl%0d bit%0d got=%h want=%h",
                 ovl, i + 1, obs(), mexp());
      end
    end
    checks++;
    if (zs !== want_z || match_cnt !== 8'(want_cnt) || busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_sum_ovl%0d z=%b cnt=%0d want z=%b cnt=%0d",
               ovl, zs, match_cnt, want_z, want_cnt);
    end
    abort = 1; tick(); tick();
  endtask

  task automatic test_target();
    logic [5:0] s = 6'b101010;
    cfg(8'b1010, 4, 1, 2, 0);
    go();
    for (int i = 0; i < 6; i++) begin
      bitin(s[5-i]);
      checks++;
      if (obs() !== mexp()) begin
        errors++;
        $display("FAIL target bit%0d got=%h want=%h",
                 i + 1, obs(), mexp());
      end
    end
    checks++;
    if ({done, busy, timeout, match_cnt} !== {3'b110, 8'd2}) begin
      errors++;
      $display("FAIL target_done d=%b b=%b t=%b cnt=%0d want 1 1 0 2",
               done, busy, timeout, match_cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL target_idle busy=%b done=%b want 0 0", busy, done);
    end
    go();
    checks++;
    if (busy !== 1'b1 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL restart busy=%b cnt=%0d want 1 0", busy, match_cnt);
    end
    abort = 1; tick(); tick();
  endtask

  task automatic test_timeout();
    logic [4:0] s = 5'b10101;
    cfg(8'b1111, 4, 1, 0, 5);
    go();
    for (int i = 0; i < 5; i++) bitin(s[4-i]);
    checks++;
    if ({done, timeout, match_cnt} !== {2'b11, 8'd0}) begin
      errors++;
      $display("FAIL timeout_end d=%b t=%b cnt=%0d want 1 1 0",
               done, timeout, match_cnt);
    end
    tick();
    cfg(8'b1111, 4, 1, 1, 4);
    go();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got=%b want=0", timeout);
    end
    for (int i = 0; i < 4; i++) bitin(1);
    checks++;
    if ({z, done, timeout, match_cnt} !== {3'b110, 8'd1}) begin
      errors++;
      $display("FAIL target_wins z=%b d=%b t=%b cnt=%0d want 1 1 0 1",
               z, done, timeout, match_cnt);
    end
    tick();
  endtask

  task automatic test_cfg_err();
    cfg(8'hFF, 0, 0, 0, 0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_len0 got=%b want=1", cfg_err);
    end
    cfg(8'hFF, PW + 1, 0, 0, 0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_len9 got=%b want=1", cfg_err);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_pulse got=%b want=0", cfg_err);
    end
    // previous config (1111, len 4, target 1) must still be active
    go();
    bitin(1); bitin(1);
    cfg_we = 1; cfg_len = 0; cfg_pat = 8'h00;
    bitin(1);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_run_ignored cfg_err=%b want=0", cfg_err);
    end
    bitin(1);
    checks++;
    if ({z, done, match_cnt} !== {2'b11, 8'd1} || obs() !== mexp()) begin
      errors++;
      $display("FAIL cfg_retained got=%h want=%h", obs(), mexp());
    end
    tick();
  endtask

  task automatic test_reset_abort();
    cfg(8'b1010, 4, 1, 0, 0);
    go();
    bitin(1); bitin(0);
    #2 rst = 0;
    mdl_reset();
    #1;
    checks++;
    if (obs() !== 13'd0) begin
      errors++;
      $display("FAIL reset_midrun got=%h want=0", obs());
    end
    @(negedge clk) rst = 1;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_nodone done=%b busy=%b want 0 0", done, busy);
    end
    cfg(8'b1, 1, 1, 0, 0);
    go();
    bitin(1);
    x = 1; x_vld = 1; abort = 1;
    tick();
    checks++;
    if ({z, done, match_cnt} !== {2'b01, 8'd1}) begin
      errors++;
      $display("FAIL abort_bit z=%b d=%b cnt=%0d want 0 1 1",
               z, done, match_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    cfg(8'b1, 1, 1, 0, 0);
    go();
    for (int i = 0; i < 3; i++) begin
      bitin(1);
      checks++;
      if (z !== 1'b1 || match_cnt !== 8'(i + 1)) begin
        errors++;
        $display("FAIL b2b bit%0d z=%b cnt=%0d want z=1 cnt=%0d",
                 i + 1, z, match_cnt, i + 1);
      end
    end
    abort = 1; tick(); tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_we = 1;
        cfg_pat = 8'($urandom);
        cfg_len = 4'($urandom_range(0, 10));
        cfg_ovl = 1'($urandom);
        cfg_target = 8'($urandom_range(0, 4));
        cfg_timeout = ($urandom_range(0, 2) == 0)
                      ? 16'd0 : 16'($urandom_range(3, 40));
      end
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 63) == 0);
      x = 1'($urandom);
      x_vld = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (obs() !== mexp()) begin
        errors++;
        if (bad < 10)
          $display("FAIL random cyc%0d got=%h want=%h", c, obs(), mexp());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream(1'b1, 7'b0101000, 2);
    test_stream(1'b0, 7'b0001000, 1);
    test_target();
    test_timeout();
    test_cfg_err();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
